// File: rtl/logger_rd_mux_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : logger_rd_mux_multi_if
// Description : Command-queue, response-channel and logger-array signals of
//               the multi-channel logger read mux, bundled for port use.
// Revision    : 1.0 - initial release
// ============================================================================
interface logger_rd_mux_multi_if #(
    parameter int NUM_LOGS   = 4,
    parameter int LOG_ADDR_W = 13
);
    // Host-facing FWFT command queue
    logic                           rd_cmd_queue_empty;
    logic                           rd_cmd_queue_rd_req;
    logic [63:0]                    rd_cmd_queue_rd_data;

    // Host-facing response channel
    logic                           rd_resp_val;
    logic                           rd_resp_rdy;
    logic [63:0]                    rd_resp_data;
    logic                           rd_resp_last;

    // Logger-array side
    logic [NUM_LOGS*LOG_ADDR_W-1:0] curr_log_wr_addr;
    logic [NUM_LOGS-1:0]            has_wrapped;
    logic [NUM_LOGS-1:0]            log_rd_req_val;
    logic [LOG_ADDR_W-1:0]          log_rd_req_addr;
    logic [NUM_LOGS-1:0]            log_rd_resp_val;
    logic [NUM_LOGS*64-1:0]         log_rd_resp_data;

    modport master (
        input  rd_cmd_queue_empty,
        output rd_cmd_queue_rd_req,
        input  rd_cmd_queue_rd_data,
        output rd_resp_val,
        input  rd_resp_rdy,
        output rd_resp_data,
        output rd_resp_last,
        input  curr_log_wr_addr,
        input  has_wrapped,
        output log_rd_req_val,
        output log_rd_req_addr,
        input  log_rd_resp_val,
        input  log_rd_resp_data
    );

    modport slave (
        output rd_cmd_queue_empty,
        input  rd_cmd_queue_rd_req,
        output rd_cmd_queue_rd_data,
        input  rd_resp_val,
        output rd_resp_rdy,
        input  rd_resp_data,
        input  rd_resp_last,
        output curr_log_wr_addr,
        output has_wrapped,
        input  log_rd_req_val,
        input  log_rd_req_addr,
        output log_rd_resp_val,
        output log_rd_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/logger_rd_mux_multi.sv
`default_nettype none
// ============================================================================
// Module      : logger_rd_mux_multi
// Description : Serves log-read commands from one FWFT queue against NUM_LOGS
//               logger RAMs, with metadata queries and wrapping bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module logger_rd_mux_multi #(
    parameter int NUM_LOGS   = 4,
    parameter int LOG_ADDR_W = 13,
    parameter int LOG_SEL_W  = 4,
    parameter int BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    logger_rd_mux_multi_if.master bus
);

    typedef enum logic [1:0] {
        READY    = 2'd0,
        RD_REQ   = 2'd1,
        RD_WAIT  = 2'd2,
        RESP_OUT = 2'd3
    } state_t;

    localparam int          c_ch_lsb   = LOG_ADDR_W + 1;
    localparam logic [63:0] c_all_ones = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LOG_SEL_W-1:0]   r_ch;
    logic [LOG_SEL_W-1:0]   w_ch_nxt;
    logic [LOG_ADDR_W-1:0]  r_addr;
    logic [LOG_ADDR_W-1:0]  w_addr_nxt;
    logic [BURST_W-1:0]     r_beats_left;
    logic [BURST_W-1:0]     w_beats_left_nxt;
    logic [63:0]            r_resp_data;
    logic [63:0]            w_resp_data_nxt;
    logic                   r_resp_last;
    logic                   w_resp_last_nxt;

    logic                   w_pop;
    logic [NUM_LOGS-1:0]    w_req_val;
    logic                   w_resp_val;

    // Command word decode
    logic [LOG_ADDR_W-1:0]  w_cmd_addr;
    logic                   w_cmd_meta;
    logic [LOG_SEL_W-1:0]   w_cmd_ch;
    logic [BURST_W-1:0]     w_cmd_cnt;
    logic                   w_cmd_ch_valid;
    logic                   w_unused_cmd_bits;

    assign w_cmd_addr        = bus.rd_cmd_queue_rd_data[LOG_ADDR_W-1:0];
    assign w_cmd_meta        = bus.rd_cmd_queue_rd_data[LOG_ADDR_W];
    assign w_cmd_ch          = bus.rd_cmd_queue_rd_data[c_ch_lsb +: LOG_SEL_W];
    assign w_cmd_cnt         = bus.rd_cmd_queue_rd_data[32 +: BURST_W];
    assign w_cmd_ch_valid    = (int'(w_cmd_ch) < NUM_LOGS);
    assign w_unused_cmd_bits = ^{bus.rd_cmd_queue_rd_data[63:32+BURST_W],
                                 bus.rd_cmd_queue_rd_data[31:c_ch_lsb+LOG_SEL_W]};

    // Per-channel selection: metadata by the command's channel, logger
    // response and request strobe by the latched channel.
    logic                   w_meta_wrapped;
    logic [LOG_ADDR_W-1:0]  w_meta_wr_addr;
    logic                   w_sel_resp_val;
    logic [63:0]            w_sel_resp_data;
    logic [NUM_LOGS-1:0]    w_ch_onehot;

    always_comb begin
        w_meta_wrapped  = 1'b0;
        w_meta_wr_addr  = '0;
        w_sel_resp_val  = 1'b0;
        w_sel_resp_data = '0;
        w_ch_onehot     = '0;
        for (int i = 0; i < NUM_LOGS; i++) begin
            if (w_cmd_ch == LOG_SEL_W'(i)) begin
                w_meta_wrapped = bus.has_wrapped[i];
                w_meta_wr_addr = bus.curr_log_wr_addr[i*LOG_ADDR_W +: LOG_ADDR_W];
            end
            if (r_ch == LOG_SEL_W'(i)) begin
                w_sel_resp_val  = bus.log_rd_resp_val[i];
                w_sel_resp_data = bus.log_rd_resp_data[i*64 +: 64];
                w_ch_onehot[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ch_nxt         = r_ch;
        w_addr_nxt       = r_addr;
        w_beats_left_nxt = r_beats_left;
        w_resp_data_nxt  = r_resp_data;
        w_resp_last_nxt  = r_resp_last;
        w_pop            = 1'b0;
        w_req_val        = '0;
        w_resp_val       = 1'b0;

        case (r_state)
            READY: begin
                // Pop is suppressed while rst is held so no command is lost.
                if (!bus.rd_cmd_queue_empty && !rst) begin
                    w_pop            = 1'b1;
                    w_ch_nxt         = w_cmd_ch;
                    w_addr_nxt       = w_cmd_addr;
                    w_beats_left_nxt = (w_cmd_cnt == '0) ? '0 : (w_cmd_cnt - BURST_W'(1));
                    if (!w_cmd_ch_valid) begin
                        w_resp_data_nxt = c_all_ones;
                        w_resp_last_nxt = 1'b1;
                        w_state_nxt     = RESP_OUT;
                    end else if (w_cmd_meta) begin
                        w_resp_data_nxt = (w_cmd_addr == '0) ?
                                          64'({w_meta_wrapped, w_meta_wr_addr}) : c_all_ones;
                        w_resp_last_nxt = 1'b1;
                        w_state_nxt     = RESP_OUT;
                    end else begin
                        w_state_nxt = RD_REQ;
                    end
                end
            end

            RD_REQ: begin
                w_req_val   = w_ch_onehot;
                w_state_nxt = RD_WAIT;
            end

            RD_WAIT: begin
                if (w_sel_resp_val) begin
                    w_resp_data_nxt = w_sel_resp_data;
                    w_resp_last_nxt = (r_beats_left == '0);
                    w_state_nxt     = RESP_OUT;
                end
            end

            RESP_OUT: begin
                w_resp_val = 1'b1;
                if (bus.rd_resp_rdy) begin
                    if (r_resp_last) begin
                        w_state_nxt = READY;
                    end else begin
                        w_addr_nxt       = r_addr + LOG_ADDR_W'(1);
                        w_beats_left_nxt = r_beats_left - BURST_W'(1);
                        w_state_nxt      = RD_REQ;
                    end
                end
            end

            default: begin
                w_state_nxt = READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= READY;
            r_ch         <= '0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_resp_data  <= '0;
            r_resp_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch         <= w_ch_nxt;
            r_addr       <= w_addr_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_last  <= w_resp_last_nxt;
        end
    end

    assign bus.rd_cmd_queue_rd_req = w_pop;
    assign bus.log_rd_req_val      = w_req_val;
    assign bus.log_rd_req_addr     = r_addr;
    assign bus.rd_resp_val         = w_resp_val;
    assign bus.rd_resp_data        = r_resp_data;
    assign bus.rd_resp_last        = r_resp_last;

endmodule
`default_nettype wire

// File: tb/tb_logger_rd_mux_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_logger_rd_mux_multi
// Description : Directed self-checking bench for logger_rd_mux_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logger_rd_mux_multi;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    logger_rd_mux_multi_if #(.NUM_LOGS(4), .LOG_ADDR_W(13)) bus ();

    logger_rd_mux_multi #(
        .NUM_LOGS   (4),
        .LOG_ADDR_W (13),
        .LOG_SEL_W  (4),
        .BURST_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Command word with junk in every ignored field.
    function automatic logic [63:0] mk(input int ch, input logic meta,
                                       input logic [12:0] addr, input int cnt);
        logic [63:0] w;
        w        = 64'hA5A5_A500_AAAC_0000;
        w[12:0]  = addr;
        w[13]    = meta;
        w[17:14] = 4'(ch);
        w[39:32] = 8'(cnt);
        return w;
    endfunction

    task automatic pop_cmd(input logic [63:0] w, input logic next_valid, input logic [63:0] next_w);
        bus.rd_cmd_queue_rd_data = w;
        bus.rd_cmd_queue_empty   = 1'b0;
        #1;
        check("pop_strobe", bus.rd_cmd_queue_rd_req, 1);
        check("pop_no_req", bus.log_rd_req_val, 0);
        tick();
        if (next_valid) bus.rd_cmd_queue_rd_data = next_w;
        else            bus.rd_cmd_queue_empty   = 1'b1;
    endtask

    task automatic serve(input int ch, input logic [12:0] addr, input logic [63:0] data, input logic noise);
        #1;
        check("req_onehot", bus.log_rd_req_val, 64'(4'(1) << ch));
        check("req_addr", bus.log_rd_req_addr, addr);
        check("req_no_resp", bus.rd_resp_val, 0);
        check("req_no_pop", bus.rd_cmd_queue_rd_req, 0);
        tick();
        if (noise) begin
            bus.log_rd_resp_val = 4'b1000;
            bus.log_rd_resp_data[3*64 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            bus.log_rd_resp_val = '0;
            #1;
            check("noise_no_resp", bus.rd_resp_val, 0);
            check("noise_no_req", bus.log_rd_req_val, 0);
        end
        bus.log_rd_resp_val = 4'(1) << ch;
        bus.log_rd_resp_data[ch*64 +: 64] = data;
        tick();
        bus.log_rd_resp_val = '0;
    endtask

    task automatic take(input logic [63:0] data, input logic last);
        #1;
        check("resp_val", bus.rd_resp_val, 1);
        check("resp_data", bus.rd_resp_data, data);
        check("resp_last", bus.rd_resp_last, last);
        check("resp_no_req", bus.log_rd_req_val, 0);
        check("resp_no_pop", bus.rd_cmd_queue_rd_req, 0);
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst                      = 1'b1;
        bus.rd_cmd_queue_empty   = 1'b1;
        bus.rd_cmd_queue_rd_data = '0;
        bus.rd_resp_rdy          = 1'b1;
        bus.curr_log_wr_addr     = {13'h0AAA, 13'h0555, 13'h0123, 13'h0FFF};
        bus.has_wrapped          = 4'b0010;
        bus.log_rd_resp_val      = '0;
        bus.log_rd_resp_data     = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_pop", bus.rd_cmd_queue_rd_req, 0);
        check("rst_val", bus.rd_resp_val, 0);
        check("rst_data", bus.rd_resp_data, 0);
        check("rst_last", bus.rd_resp_last, 0);
        check("rst_req", bus.log_rd_req_val, 0);

        // Single read, channel 2
        pop_cmd(mk(2, 1'b0, 13'h0005, 1), 1'b0, '0);
        serve(2, 13'h0005, 64'h0000_0000_DEAD_BEEF, 1'b0);
        take(64'h0000_0000_DEAD_BEEF, 1'b1);
        #1;
        check("single_idle", bus.rd_resp_val, 0);

        // Wrapping burst of 4 on channel 0 with a metadata command already queued
        pop_cmd(mk(0, 1'b0, 13'h1FFE, 4), 1'b1, mk(1, 1'b1, 13'h0000, 5));
        serve(0, 13'h1FFE, 64'h1111_0000_0000_1FFE, 1'b0);
        take(64'h1111_0000_0000_1FFE, 1'b0);
        serve(0, 13'h1FFF, 64'h2222_0000_0000_1FFF, 1'b0);
        take(64'h2222_0000_0000_1FFF, 1'b0);
        serve(0, 13'h0000, 64'h3333_0000_0000_0000, 1'b0);
        take(64'h3333_0000_0000_0000, 1'b0);
        serve(0, 13'h0001, 64'h4444_0000_0000_0001, 1'b0);
        take(64'h4444_0000_0000_0001, 1'b1);

        // Metadata: addr 0 returns wrapped flag and write pointer, sampled at pop
        pop_cmd(mk(1, 1'b1, 13'h0000, 5), 1'b1, mk(1, 1'b1, 13'h0003, 0));
        bus.curr_log_wr_addr[13 +: 13] = 13'h0777;
        take(64'h0000_0000_0000_2123, 1'b1);
        pop_cmd(mk(1, 1'b1, 13'h0003, 0), 1'b1, mk(9, 1'b0, 13'h0055, 1));
        take(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Out-of-range channel
        pop_cmd(mk(9, 1'b0, 13'h0055, 1), 1'b0, '0);
        take(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        #1;
        check("badch_no_req", bus.log_rd_req_val, 0);
        check("badch_idle", bus.rd_resp_val, 0);

        // Backpressure on beat 1, stray responses ignored
        pop_cmd(mk(1, 1'b0, 13'h0010, 2), 1'b0, '0);
        serve(1, 13'h0010, 64'h5555_AAAA_0000_0010, 1'b0);
        bus.rd_resp_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("hold_val", bus.rd_resp_val, 1);
            check("hold_data", bus.rd_resp_data, 64'h5555_AAAA_0000_0010);
            check("hold_last", bus.rd_resp_last, 0);
            check("hold_no_req", bus.log_rd_req_val, 0);
            if (k == 2) begin
                bus.log_rd_resp_val  = 4'b1010;
                bus.log_rd_resp_data = {4{64'hBADB_ADBA_DBAD_BAD0}};
            end
            tick();
            bus.log_rd_resp_val = '0;
        end
        bus.rd_resp_rdy = 1'b1;
        take(64'h5555_AAAA_0000_0010, 1'b0);
        serve(1, 13'h0011, 64'h6666_BBBB_0000_0011, 1'b1);
        take(64'h6666_BBBB_0000_0011, 1'b1);

        // Reset during RD_WAIT of a 3-beat burst
        pop_cmd(mk(2, 1'b0, 13'h0040, 3), 1'b0, '0);
        serve(2, 13'h0040, 64'h7777_0000_0000_0040, 1'b0);
        take(64'h7777_0000_0000_0040, 1'b0);
        #1;
        check("b2_req_addr", bus.log_rd_req_addr, 13'h0041);
        check("b2_req_onehot", bus.log_rd_req_val, 4'b0100);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_pop", bus.rd_cmd_queue_rd_req, 0);
        check("mid_rst_val", bus.rd_resp_val, 0);
        check("mid_rst_data", bus.rd_resp_data, 0);
        check("mid_rst_last", bus.rd_resp_last, 0);
        check("mid_rst_req", bus.log_rd_req_val, 0);
        check("mid_rst_addr", bus.log_rd_req_addr, 0);
        bus.log_rd_resp_val = 4'b0100;
        bus.log_rd_resp_data[2*64 +: 64] = 64'hDEAD_0000_0000_0041;
        tick();
        bus.log_rd_resp_val = '0;
        #1;
        check("late_resp_val", bus.rd_resp_val, 0);
        check("late_resp_req", bus.log_rd_req_val, 0);
        tick();
        #1;
        check("late_resp_val2", bus.rd_resp_val, 0);
        pop_cmd(mk(2, 1'b0, 13'h0007, 1), 1'b0, '0);
        serve(2, 13'h0007, 64'h8888_0000_0000_0007, 1'b0);
        take(64'h8888_0000_0000_0007, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logger_rd_mux_multi.md
Name: logger_rd_mux_multi

Overview:
- Serves log-read commands from a single FWFT command queue against NUM_LOGS independent logger RAMs.
- Routes each read to the selected logger and returns the data on a valid/ready response channel.
- Supports per-channel metadata queries and multi-beat burst reads with address wrap-around.
- Sits between the host-facing log command/response queues and the per-block logger instances; it is the multi-channel, backpressured successor of the single-logger address mux.

Parameters:
- NUM_LOGS, 4: number of attached loggers (1..2^LOG_SEL_W).
- LOG_ADDR_W, 13: logger entry address width.
- LOG_SEL_W, 4: width of the channel-select field in the command.
- BURST_W, 8: width of the burst-length field in the command.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_cmd_queue_empty  in  1  command queue empty.
- rd_cmd_queue_rd_req  out  1  pop strobe; data is valid in the same cycle (FWFT).
- rd_cmd_queue_rd_data  in  64  command word.
- rd_resp_val  out  1  response beat valid.
- rd_resp_rdy  in  1  consumer ready.
- rd_resp_data  out  64  response beat.
- rd_resp_last  out  1  final beat of the command.
- curr_log_wr_addr  in  NUM_LOGS*LOG_ADDR_W  per-channel write pointer; channel i at [i*LOG_ADDR_W +: LOG_ADDR_W].
- has_wrapped  in  NUM_LOGS  per-channel wrapped flag.
- log_rd_req_val  out  NUM_LOGS  one-hot read request.
- log_rd_req_addr  out  LOG_ADDR_W  read address, shared by all channels.
- log_rd_resp_val  in  NUM_LOGS  per-channel read response valid.
- log_rd_resp_data  in  NUM_LOGS*64  per-channel read data; channel i at [i*64 +: 64].

Behaviour:
- Command word fields:
  - [LOG_ADDR_W-1:0] start addr.
  - [LOG_ADDR_W] get_metadata.
  - [LOG_ADDR_W+1 +: LOG_SEL_W] channel.
  - [32 +: BURST_W] beat count; 0 is treated as 1.
  - All other bits are ignored.
- Reset: state READY, all registers cleared. rd_cmd_queue_rd_req=0, log_rd_req_val=0, rd_resp_val=0, rd_resp_data=0, rd_resp_last=0.
- States: READY, RD_REQ, RD_WAIT, RESP_OUT.
- READY:
  - If ~rd_cmd_queue_empty: pop (rd_cmd_queue_rd_req=1 for exactly 1 cycle) and latch channel, addr, beats_left = max(count,1)-1.
  - channel >= NUM_LOGS: load resp reg with all-ones, last=1, go to RESP_OUT.
  - Else get_metadata=1: load resp reg with {zeros, has_wrapped[ch], curr_log_wr_addr[ch]} if addr==0, else all-ones; last=1; go to RESP_OUT. Burst count is ignored.
  - Else go to RD_REQ.
- RD_REQ: log_rd_req_val[ch]=1 for exactly one cycle, log_rd_req_addr=current addr; go to RD_WAIT.
- RD_WAIT:
  - Wait for log_rd_resp_val[ch]; capture log_rd_resp_data[ch] into resp reg and set last=(beats_left==0); go to RESP_OUT.
  - Response valids from other channels are ignored in every state.
  - Any log_rd_resp_val seen in READY or RESP_OUT is dropped.
- RESP_OUT:
  - rd_resp_val=1; rd_resp_data and rd_resp_last come straight from registers and are held stable until rd_resp_rdy.
  - On handshake with last=1: go to READY. No pop occurs in the handshake cycle; the next pop is at the earliest in the following cycle.
  - On handshake with last=0: addr <= addr+1 modulo 2^LOG_ADDR_W (e.g. 2^LOG_ADDR_W-1 wraps to 0), beats_left--, go to RD_REQ.
- Latency with a 1-cycle logger and rdy=1:
  - Pop at T, req at T+1, logger resp at T+2, rd_resp_val at T+3; each further burst beat follows 3 cycles later.
  - Metadata/invalid commands: rd_resp_val at T+1.
- log_rd_req_addr is driven from the addr register at all times; it is meaningful only when a request valid is high.
- Exactly one command is in flight; no new pop until the final beat has handshaken.
- Metadata inputs are sampled in the pop cycle.
- rst asserted mid-burst: return to READY next cycle and abandon remaining beats. rd_resp_val drops. In-flight logger responses arriving after reset are ignored.

Test Plan:
- Channel 2, addr 5, count 1, logger 2 returns 0xDEAD_BEEF after 1 cycle, rdy=1 -> one pop; log_rd_req_val=4'b0100 with addr 5 at T+1; rd_resp_data=0xDEADBEEF, last=1 at T+3.
- Channel 0, addr 0x1FFE, count 4 -> request addrs 0x1FFE, 0x1FFF, 0x0000, 0x0001 in order; four beats with last=1 only on the fourth; exactly one pop.
- Metadata channel 1, addr 0, has_wrapped[1]=1, wr_addr[1]=0x0123 -> resp 0x0000_0000_0000_2123 at T+1 with last=1 and no log request; same command with addr 3 -> resp 0xFFFF_FFFF_FFFF_FFFF.
- Channel 9 with NUM_LOGS=4 -> single all-ones beat with last=1; log_rd_req_val stays 0.
- Burst of 2 with rdy held low 5 cycles on beat 1 -> data and last held stable; second request issues only after the handshake; a spurious log_rd_resp_val[3] during the wait has no effect.
- rst pulsed during RD_WAIT of a 3-beat burst -> all outputs 0 the next cycle; a logger response arriving afterwards produces no rd_resp_val; the next queued command is served normally.
